// File: rtl/spi_tx_scheduler.sv
// Round-robin arbitrates two TX byte requesters into a FIFO and exports one byte per SPI tick.
// cdc_stb follows a tick by one cycle unless cdc_busy holds it; a full FIFO deasserts both readies.
module spi_tx_scheduler #(
    parameter int         pDepth    = 4,
    parameter logic [7:0] pIdleByte = 8'hFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                req0_data,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [7:0]                req1_data,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic                      tick,
    input  logic                      cdc_busy,
    output logic [7:0]                cdc_data,
    output logic                      cdc_stb,
    output logic [$clog2(pDepth):0]   level,
    output logic [7:0]                underruns,
    output logic [7:0]                missed
);
    localparam int AW = $clog2(pDepth);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_nxt;
    logic [7:0]    mem [pDepth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          rr;
    logic          can_push, grant0, grant1, push, pop, load;
    logic [7:0]    push_data;

    // Registered level gates the grant, so a pop while full cannot free a slot in the same cycle.
    assign can_push   = (level != LW'(pDepth));
    assign grant0     = can_push && req0_valid && (!req1_valid || !rr);
    assign grant1     = can_push && req1_valid && (!req0_valid || rr);
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign push       = grant0 || grant1;
    assign push_data  = grant1 ? req1_data : req0_data;

    always_comb begin
        state_nxt = state;
        cdc_stb   = 1'b0;
        load      = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    load      = 1'b1;
                    pop       = (level != '0);
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (!cdc_busy) begin
                    cdc_stb   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rr        <= 1'b0;
            cdc_data  <= pIdleByte;
            underruns <= 8'd0;
            missed    <= 8'd0;
        end else begin
            state <= state_nxt;
            if (req0_valid && req1_valid && push) begin
                rr <= ~rr;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (load) begin
                if (pop) begin
                    cdc_data <= mem[rd_ptr];
                end else begin
                    cdc_data <= pIdleByte;
                    if (underruns != 8'hFF) begin
                        underruns <= underruns + 8'd1;
                    end
                end
            end
            if (state == SEND && tick && missed != 8'hFF) begin
                missed <= missed + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_spi_tx_scheduler;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] IDLE_B = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic       tick = 1'b0, cdc_busy = 1'b0;
    logic [7:0] cdc_data;
    logic       cdc_stb;
    logic [2:0] level;
    logic [7:0] underruns, missed;

    always #5 clk = ~clk;

    spi_tx_scheduler #(.pDepth(DEPTH), .pIdleByte(IDLE_B)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .tick(tick), .cdc_busy(cdc_busy),
        .cdc_data(cdc_data), .cdc_stb(cdc_stb),
        .level(level), .underruns(underruns), .missed(missed)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model: byte queue in grant order, one pending export slot, plain saturating counts.
    logic [7:0] byte_q[$];
    logic [7:0] stb_log[$];
    bit         m_rr = 1'b0;
    bit         m_pend = 1'b0;
    logic [7:0] m_hold = IDLE_B;
    int         m_und = 0;
    int         m_mis = 0;

    always @(negedge clk) begin : compare
        int   g;
        logic exp_stb;
        if (!rst_n) begin
            chk("rst_level", level, 0);
            chk("rst_stb", cdc_stb, 0);
            chk("rst_data", cdc_data, IDLE_B);
            chk("rst_underruns", underruns, 0);
            chk("rst_missed", missed, 0);
            byte_q.delete();
            m_rr = 1'b0; m_pend = 1'b0; m_hold = IDLE_B; m_und = 0; m_mis = 0;
        end else begin
            g = -1;
            if (byte_q.size() < DEPTH) begin
                if (req0_valid && req1_valid) begin
                    g = m_rr ? 1 : 0;
                    m_rr = ~m_rr;
                end else if (req0_valid) g = 0;
                else if (req1_valid) g = 1;
            end
            chk("ready0", req0_ready, g == 0);
            chk("ready1", req1_ready, g == 1);
            exp_stb = m_pend && !cdc_busy;
            chk("stb", cdc_stb, exp_stb);
            if (exp_stb) chk("cdc_data", cdc_data, m_hold);
            chk("level", level, byte_q.size());
            chk("underruns", underruns, m_und);
            chk("missed", missed, m_mis);
            if (cdc_stb) stb_log.push_back(cdc_data);
            if (m_pend) begin
                if (tick && m_mis < 255) m_mis++;
                if (!cdc_busy) m_pend = 1'b0;
            end else if (tick) begin
                if (byte_q.size() > 0) m_hold = byte_q.pop_front();
                else begin
                    m_hold = IDLE_B;
                    if (m_und < 255) m_und++;
                end
                m_pend = 1'b1;
            end
            if (g == 0) byte_q.push_back(req0_data);
            if (g == 1) byte_q.push_back(req1_data);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    initial begin
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Empty tick exports the idle byte next cycle.
        stb_log.delete();
        pulse_tick();
        cyc(2);
        chk("t1_stb_count", stb_log.size(), 1);
        if (stb_log.size() > 0) chk("t1_idle_byte", stb_log[0], 8'hFF);
        chk("t1_underruns", underruns, 1);

        // Two bytes from requester 0, exported in order.
        stb_log.delete();
        req0_valid = 1'b1; req0_data = 8'hA5;
        cyc(1);
        req0_data = 8'h5A;
        cyc(1);
        req0_valid = 1'b0;
        chk("t2_level2", level, 2);
        pulse_tick();
        chk("t2_level1", level, 1);
        cyc(7);
        pulse_tick();
        chk("t2_level0", level, 0);
        cyc(3);
        chk("t2_stb_count", stb_log.size(), 2);
        if (stb_log.size() == 2) begin
            chk("t2_first", stb_log[0], 8'hA5);
            chk("t2_second", stb_log[1], 8'h5A);
        end

        // Contention alternates grants.
        stb_log.delete();
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_data = 8'h10 + 8'(i / 2);
            req1_data = 8'h20 + 8'(i / 2);
            @(negedge clk);
            chk("t3_grant0", req0_ready, (i % 2) == 0);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t3_level", level, 4);
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            cyc(2);
        end
        chk("t3_stb_count", stb_log.size(), 4);
        if (stb_log.size() == 4) begin
            chk("t3_b0", stb_log[0], 8'h10);
            chk("t3_b1", stb_log[1], 8'h20);
            chk("t3_b2", stb_log[2], 8'h11);
            chk("t3_b3", stb_log[3], 8'h21);
        end

        // Fill via requester 1, pop, refill on the following cycle.
        req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req1_data = 8'h30 + 8'(i);
            cyc(1);
        end
        @(negedge clk);
        chk("t4_full", level, 4);
        chk("t4_ready_full", req1_ready, 0);
        @(posedge clk); #1;
        tick = 1'b1;
        @(negedge clk);
        chk("t4_ready_popcycle", req1_ready, 0);
        @(posedge clk); #1;
        tick = 1'b0;
        chk("t4_level3", level, 3);
        @(negedge clk);
        chk("t4_ready_refill", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        chk("t4_level_refilled", level, 4);
        cyc(2);

        // Busy exporter, second tick dropped.
        stb_log.delete();
        cdc_busy = 1'b1;
        pulse_tick();
        cyc(1);
        pulse_tick();
        cyc(3);
        cdc_busy = 1'b0;
        cyc(3);
        chk("t5_stb_count", stb_log.size(), 1);
        chk("t5_missed", missed, 1);

        // Reset mid-SEND, then saturate underruns.
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_data = 8'h40 + 8'(i);
            cyc(1);
        end
        req0_valid = 1'b0;
        cdc_busy = 1'b1;
        pulse_tick();
        chk("t6_level3", level, 3);
        cyc(1);
        rst_n = 1'b0;
        stb_log.delete();
        cyc(2);
        cdc_busy = 1'b0;
        rst_n = 1'b1;
        cyc(3);
        chk("t6_no_stb", stb_log.size(), 0);
        chk("t6_level", level, 0);
        chk("t6_underruns", underruns, 0);
        chk("t6_missed", missed, 0);
        for (int i = 0; i < 300; i++) begin
            pulse_tick();
            cyc(2);
        end
        chk("t6_sat", underruns, 255);
        chk("t6_level_end", level, 0);

        // Randomized traffic against the model.
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(0, 1) == 1);
            req1_valid = ($urandom_range(0, 1) == 1);
            req0_data  = 8'($urandom);
            req1_data  = 8'($urandom);
            tick       = ($urandom_range(0, 5) == 0);
            cdc_busy   = ($urandom_range(0, 2) == 0);
            cyc(1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; tick = 1'b0; cdc_busy = 1'b0;
        cyc(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
